keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed 7-segment display path: scans a 4x4 matrix keypad by driving one column low at a time and reading the rows.
- Debounces one keypress and emits a hex key code with a one-cycle valid strobe.
- Shifts each accepted key into a 16-bit, 4-digit buffer whose nibbles map directly onto the display mux digit inputs D0..D3.
- Sits between the board keypad header and the display mux, clocked from the 50 MHz board clock.

---
 rtl/keypad_scanner.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scan, debounce and 4-digit hex buffer.
// DIGITS nibbles map straight onto the display mux inputs D0..D3.
module keypad_scanner #(
   parameter int CLK_HZ         = 50000000,
   parameter int SCAN_HZ        = 1000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic        CLK,
   input  logic        CLEAR,
   input  logic [3:0]  ROW,
   output logic [3:0]  COL,
   output logic [3:0]  KEY,
   output logic        KEY_VALID,
   output logic        HELD,
   output logic [15:0] DIGITS
);

   localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
   localparam int DW       = $clog2(SCAN_DIV);
   localparam int CW       = $clog2(DEBOUNCE_SCANS + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DEB,
      S_PRESS,
      S_REL
   } state_t;

   logic [DW-1:0] r_div;
   logic [1:0]    r_col_idx;
   logic [3:0]    r_row_s1;
   logic [3:0]    r_row_s2;
   logic [1:0]    r_hits;
   logic [3:0]    r_code;
   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_cand;
   logic [3:0]    r_key;
   logic [15:0]   r_digits;
   logic          r_valid;

   logic          w_tick;
   logic          w_scan_done;
   logic [3:0]    w_low;
   logic [2:0]    w_col_hits;
   logic [1:0]    w_row_idx;
   logic [2:0]    w_sum;
   logic [1:0]    w_tot;
   logic [3:0]    w_code;
   logic          w_none;
   logic          w_single;
   state_t        w_state_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [3:0]    w_cand_nx;
   logic          w_accept;

   function automatic logic [3:0] f_keymap(
      input logic [1:0] r,
      input logic [1:0] c
   );
      logic [3:0] v;
      v = 4'h0;
      case ({r, c})
         4'h0: v = 4'h1;
         4'h1: v = 4'h2;
         4'h2: v = 4'h3;
         4'h3: v = 4'hA;
         4'h4: v = 4'h4;
         4'h5: v = 4'h5;
         4'h6: v = 4'h6;
         4'h7: v = 4'hB;
         4'h8: v = 4'h7;
         4'h9: v = 4'h8;
         4'hA: v = 4'h9;
         4'hB: v = 4'hC;
         4'hC: v = 4'hE;
         4'hD: v = 4'h0;
         4'hE: v = 4'hF;
         default: v = 4'hD;
      endcase
      return v;
   endfunction

   assign w_tick      = (r_div == DW'(SCAN_DIV - 1));
   assign w_scan_done = w_tick && (r_col_idx == 2'd3);
   assign w_low       = ~r_row_s2;

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         r_div     <= '0;
         r_col_idx <= 2'd0;
         r_row_s1  <= 4'hF;
         r_row_s2  <= 4'hF;
      end else begin
         r_row_s1 <= ROW;
         r_row_s2 <= r_row_s1;
         if (w_tick) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
         end else begin
            r_div <= r_div + DW'(1);
         end
      end
   end

   // Hit count saturates at 2: anything beyond one intersection is MULTI.
   always_comb begin
      w_col_hits = 3'(w_low[0]) + 3'(w_low[1])
                 + 3'(w_low[2]) + 3'(w_low[3]);
      w_row_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (w_low[i]) w_row_idx = 2'(i);
      end
      w_sum  = {1'b0, r_hits} + w_col_hits;
      w_tot  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
      w_code = (w_col_hits == 3'd1) ?
               f_keymap(w_row_idx, r_col_idx) : r_code;
      w_none   = (w_tot == 2'd0);
      w_single = (w_tot == 2'd1);
   end

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         r_hits <= 2'd0;
         r_code <= 4'h0;
      end else if (w_tick) begin
         if (r_col_idx == 2'd3) begin
            r_hits <= 2'd0;
            r_code <= 4'h0;
         end else begin
            r_hits <= w_tot;
            r_code <= w_code;
         end
      end
   end

   always_ff @(posedge CLK or negedge CLEAR) begin
      if (!CLEAR) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_cand   <= 4'h0;
         r_key    <= 4'h0;
         r_digits <= 16'h0000;
         r_valid  <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_cand  <= w_cand_nx;
         r_valid <= w_accept;
         if (w_accept) begin
            r_key    <= r_cand;
            r_digits <= {r_digits[11:0], r_cand};
         end
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_cand_nx  = r_cand;
      w_accept   = 1'b0;
      if (w_scan_done) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_single) begin
                  w_state_nx = S_DEB;
                  w_cand_nx  = w_code;
                  w_cnt_nx   = CW'(1);
               end
            end
            S_DEB: begin
               if (w_single && (w_code == r_cand)) begin
                  if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                     w_state_nx = S_PRESS;
                     w_cnt_nx   = '0;
                     w_accept   = 1'b1;
                  end else begin
                     w_cnt_nx = r_cnt + CW'(1);
                  end
               end else if (w_single) begin
                  w_cand_nx = w_code;
                  w_cnt_nx  = CW'(1);
               end else begin
                  w_state_nx = S_IDLE;
                  w_cnt_nx   = '0;
               end
            end
            S_PRESS: begin
               if (w_none) begin
                  w_state_nx = S_REL;
                  w_cnt_nx   = CW'(1);
               end
            end
            S_REL: begin
               if (w_none) begin
                  if (r_cnt == CW'(DEBOUNCE_SCANS - 1)) begin
                     w_state_nx = S_IDLE;
                     w_cnt_nx   = '0;
                  end else begin
                     w_cnt_nx = r_cnt + CW'(1);
                  end
               end else begin
                  w_state_nx = S_PRESS;
                  w_cnt_nx   = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      COL       = ~(4'b0001 << r_col_idx);
      KEY       = r_key;
      KEY_VALID = r_valid;
      HELD      = (r_state == S_PRESS) || (r_state == S_REL);
      DIGITS    = r_digits;
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-level keypad model driving keypad_scanner,
// checked against a streak-based debounce reference.
module tb_keypad_scanner;

   localparam int DS = 2;

   logic        CLK = 1'b0;
   logic        CLEAR;
   logic [3:0]  ROW;
   logic [3:0]  COL;
   logic [3:0]  KEY;
   logic        KEY_VALID;
   logic        HELD;
   logic [15:0] DIGITS;

   logic [15:0] r_keys;
   int          n_vec = 0;
   int          n_err = 0;

   logic [3:0]  m_map [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
   bit          m_held;
   int          m_streak;
   int          m_none;
   logic [3:0]  m_last;
   logic [3:0]  m_key;
   logic [15:0] m_dig;

   always #5 CLK = ~CLK;

   keypad_scanner #(
      .CLK_HZ(16),
      .SCAN_HZ(4),
      .DEBOUNCE_SCANS(DS)
   ) u_dut (
      .CLK(CLK),
      .CLEAR(CLEAR),
      .ROW(ROW),
      .COL(COL),
      .KEY(KEY),
      .KEY_VALID(KEY_VALID),
      .HELD(HELD),
      .DIGITS(DIGITS)
   );

   // Pressed key at (r,c) shorts row r to column c.
   always_comb begin
      ROW = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (r_keys[r*4+c] && !COL[c]) ROW[r] = 1'b0;
         end
      end
   end

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_held   = 1'b0;
      m_streak = 0;
      m_none   = 0;
      m_last   = 4'h0;
      m_key    = 4'h0;
      m_dig    = 16'h0000;
   endtask

   task automatic model_scan(input logic [15:0] s, output int acc);
      int         n;
      logic [3:0] code;
      n    = $countones(s);
      code = 4'h0;
      acc  = 0;
      for (int j = 0; j < 16; j++) if (s[j]) code = m_map[j];
      if (!m_held) begin
         if (n == 1) begin
            if (m_streak > 0 && code == m_last) m_streak++;
            else begin
               m_streak = 1;
               m_last   = code;
            end
            if (m_streak == DS) begin
               m_held   = 1'b1;
               m_streak = 0;
               m_none   = 0;
               m_key    = code;
               m_dig    = {m_dig[11:0], code};
               acc      = 1;
            end
         end else begin
            m_streak = 0;
         end
      end else if (n == 0) begin
         m_none++;
         if (m_none == DS) begin
            m_held   = 1'b0;
            m_none   = 0;
            m_streak = 0;
         end
      end else begin
         m_none = 0;
      end
   endtask

   task automatic run_scan(input logic [15:0] s);
      int         pulses;
      int         acc;
      logic [3:0] exp_col;
      pulses = 0;
      r_keys = s;
      for (int i = 1; i <= 16; i++) begin
         @(posedge CLK);
         #1;
         if (KEY_VALID) pulses++;
         exp_col = ~(4'b0001 << ((i / 4) % 4));
         chk("col", COL, exp_col);
      end
      model_scan(s, acc);
      chk("pulse", pulses, acc);
      chk("key", KEY, m_key);
      chk("held", HELD, m_held);
      chk("digits", DIGITS, m_dig);
   endtask

   task automatic do_reset();
      CLEAR = 1'b0;
      #3;
      chk("rst_col", COL, 4'b1110);
      chk("rst_key", KEY, 4'h0);
      chk("rst_valid", KEY_VALID, 1'b0);
      chk("rst_held", HELD, 1'b0);
      chk("rst_digits", DIGITS, 16'h0000);
      model_reset();
      repeat (2) @(posedge CLK);
      #1;
      CLEAR = 1'b1;
   endtask

   task automatic tap(input logic [15:0] s, input int on, input int off);
      repeat (on) run_scan(s);
      repeat (off) run_scan(16'h0000);
   endtask

   initial begin
      logic [15:0] s;
      int          run;
      int          sel;
      CLEAR  = 1'b1;
      r_keys = 16'h0000;
      #2;
      do_reset();

      repeat (4) run_scan(16'h0000);
      chk("idle_digits", DIGITS, 16'h0000);

      tap(16'h0020, 4, 0);
      chk("k5_digits", DIGITS, 16'h0005);
      tap(16'h0000, 3, 0);
      chk("k5_released", HELD, 1'b0);

      tap(16'h0001, 3, 3);
      tap(16'h0002, 3, 3);
      tap(16'h0004, 3, 3);
      tap(16'h0008, 3, 3);
      chk("dig_123A", DIGITS, 16'h123A);
      tap(16'h2000, 3, 3);
      chk("dig_23A0", DIGITS, 16'h23A0);

      tap(16'h0100, 3, 0);
      tap(16'h0500, 3, 0);
      tap(16'h0400, 3, 0);
      chk("no_roll_key", KEY, 4'h7);
      tap(16'h0000, 3, 0);
      tap(16'h0400, 3, 3);
      chk("k9_after", KEY, 4'h9);

      run_scan(16'h0200);
      run_scan(16'h0000);
      run_scan(16'h0200);
      chk("bounce_key", KEY, 4'h9);
      run_scan(16'h0200);
      chk("k8_key", KEY, 4'h8);
      tap(16'h0000, 3, 0);

      run_scan(16'h4000);
      r_keys = 16'h4000;
      repeat (6) @(posedge CLK);
      #2;
      do_reset();
      tap(16'h4000, 3, 0);
      chk("kF_key", KEY, 4'hF);
      tap(16'h0000, 3, 0);

      for (int k = 0; k < 80; k++) begin
         run = $urandom_range(1, 4);
         sel = $urandom_range(0, 9);
         if (sel < 4) s = 16'h0000;
         else if (sel < 9) s = 16'h0001 << $urandom_range(0, 15);
         else s = (16'h0001 << $urandom_range(0, 15))
                | (16'h0001 << $urandom_range(0, 15));
         repeat (run) run_scan(s);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
